// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with load, clear, programmable terminal value and wrap pulse.
// Define BCD_CNT_SAT_EN to saturate at 0 / limit instead of wrapping.
module bcd_updown_counter_n #(
  parameter int                NDIG    = 4,
  parameter logic [4*NDIG-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              inc,
  input  logic              dir,
  input  logic [4*NDIG-1:0] limit,
  output logic [4*NDIG-1:0] value,
  output logic              tc,
  output logic              err
);

  logic [4*NDIG-1:0] r_value;
  logic              r_tc;
  logic              r_err;

  logic [4*NDIG-1:0] w_up_val;
  logic [4*NDIG-1:0] w_dn_val;
  logic              w_carry;
  logic              w_borrow;
  logic              w_load_bad;
  logic              w_limit_bad;
  logic              w_at_zero;
  logic              w_over;
  logic              w_at_top;

  // Ripple carry/borrow through every digit in one cycle: a digit steps only
  // when all lower digits are at their rollover value (9 going up, 0 going down).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_up_val    = r_value;
    w_dn_val    = r_value;
    w_carry     = 1'b1;
    w_borrow    = 1'b1;
    w_load_bad  = (load_val > limit);
    w_limit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_carry) begin
        if (r_value[4*i+:4] == 4'd9) begin
          w_up_val[4*i+:4] = 4'd0;
        end else begin
          w_up_val[4*i+:4] = r_value[4*i+:4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_value[4*i+:4] == 4'd0) begin
          w_dn_val[4*i+:4] = 4'd9;
        end else begin
          w_dn_val[4*i+:4] = r_value[4*i+:4] - 4'd1;
          w_borrow         = 1'b0;
        end
      end
      if (load_val[4*i+:4] > 4'd9) w_load_bad  = 1'b1;
      if (limit[4*i+:4] > 4'd9)    w_limit_bad = 1'b1;
    end
  end

  assign w_at_zero = (r_value == '0);
  assign w_over    = (r_value > limit);
  assign w_at_top  = (r_value == limit) || w_over;

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= RST_VAL;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_value <= RST_VAL;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_tc <= 1'b0;
      if (w_load_bad) begin
        r_value <= RST_VAL;
        r_err   <= 1'b1;
      end else begin
        r_value <= load_val;
      end
    end else if (inc) begin
      if (w_limit_bad) r_err <= 1'b1;
      if (!dir) begin
        if (w_at_top) begin
          r_tc <= 1'b1;
          if (w_over) r_err <= 1'b1;
`ifdef BCD_CNT_SAT_EN
          r_value <= limit;
`else
          r_value <= '0;
`endif
        end else begin
          r_tc    <= 1'b0;
          r_value <= w_up_val;
        end
      end else begin
        if (w_at_zero) begin
          r_tc <= 1'b1;
`ifdef BCD_CNT_SAT_EN
          r_value <= '0;
`else
          r_value <= limit;
`endif
        end else begin
          r_tc    <= 1'b0;
          r_value <= w_dn_val;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign value = r_value;
  assign tc    = r_tc;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed self-checking bench for bcd_updown_counter_n (NDIG=4); honours BCD_CNT_SAT_EN.
module tb_bcd_updown_counter_n;

`ifdef BCD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, load, inc, dir, tc, err;
  logic [15:0] load_val, limit, value;
  logic [15:0] exp_v;
  logic        exp_tc, exp_err;
  int          errors = 0;
  int          checks = 0;

  bcd_updown_counter_n #(.NDIG(4), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dir(dir), .limit(limit), .value(value), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; load = 1'b0; inc = 1'b0; dir = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); load_val = '0; limit = 16'h9999;
    #12;
    checks++;
    if ({value, tc, err} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b want 0000/0/0", value, tc, err);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_sweep();
    limit = 16'h9999; inc = 1'b1; dir = 1'b0;
    for (int k = 1; k <= 10000; k++) begin
      step();
      exp_v  = (k == 10000) ? (SAT ? 16'h9999 : 16'h0000) : to_bcd(k);
      exp_tc = (k == 10000);
      checks++;
      if ({value, tc, err} !== {exp_v, exp_tc, 1'b0}) begin
        errors++;
        $display("FAIL sweep step %0d: got %h/%b/%b want %h/%b/0", k, value, tc, err, exp_v, exp_tc);
      end
    end
    inc = 1'b0;
    step();
    checks++;
    if ({value, tc} !== {exp_v, 1'b0}) begin
      errors++;
      $display("FAIL sweep_idle: got %h/%b want %h/0", value, tc, exp_v);
    end
  endtask

  task automatic test_up_wrap(input string name, input logic [15:0] lim, input logic [15:0] start,
                              input logic [15:0] after_wrap);
    logic [15:0] ev [3];
    logic        et [3];
    idle(); limit = lim; load = 1'b1; load_val = start;
    step();
    checks++;
    if ({value, tc, err} !== {start, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_load: got %h/%b/%b want %h/0/0", name, value, tc, err, start);
    end
    ev[0] = lim;                       et[0] = 1'b0;
    ev[1] = SAT ? lim : 16'h0000;      et[1] = 1'b1;
    ev[2] = SAT ? lim : after_wrap;    et[2] = SAT;
    load = 1'b0; inc = 1'b1; dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({value, tc, err} !== {ev[k], et[k], 1'b0}) begin
        errors++;
        $display("FAIL %s_step%0d: got %h/%b/%b want %h/%b/0", name, k, value, tc, err, ev[k], et[k]);
      end
    end
    idle();
  endtask

  task automatic test_down();
    idle(); limit = 16'h0059; clr = 1'b1;
    step();
    clr = 1'b0; inc = 1'b1; dir = 1'b1;
    step();
    checks++;
    exp_v = SAT ? 16'h0000 : 16'h0059;
    if ({value, tc, err} !== {exp_v, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL down_wrap: got %h/%b/%b want %h/1/0", value, tc, err, exp_v);
    end
    step();
    checks++;
    exp_v = SAT ? 16'h0000 : 16'h0058;
    if ({value, tc} !== {exp_v, SAT}) begin
      errors++;
      $display("FAIL down_after_wrap: got %h/%b want %h/%b", value, tc, exp_v, SAT);
    end
    inc = 1'b0; load = 1'b1; load_val = 16'h0010;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    checks++;
    if ({value, tc} !== {16'h0009, 1'b0}) begin
      errors++;
      $display("FAIL down_borrow1: got %h/%b want 0009/0", value, tc);
    end
    limit = 16'h9999; inc = 1'b0; load = 1'b1; load_val = 16'h1000;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    checks++;
    if (value !== 16'h0999) begin
      errors++;
      $display("FAIL down_borrow3: got %h want 0999", value);
    end
    dir = 1'b0;
    step();
    checks++;
    if (value !== 16'h1000) begin
      errors++;
      $display("FAIL up_carry3: got %h want 1000", value);
    end
    idle();
  endtask

  task automatic test_bad_load_and_priority();
    idle(); limit = 16'h9999; load = 1'b1; load_val = 16'h001A;
    step();
    checks++;
    if ({value, tc, err} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bad_digit_load: got %h/%b/%b want 0000/0/1", value, tc, err);
    end
    load = 1'b0; inc = 1'b1;
    step();
    checks++;
    if ({value, err} !== {16'h0001, 1'b1}) begin
      errors++;
      $display("FAIL err_sticky: got %h/%b want 0001/1", value, err);
    end
    inc = 1'b0; clr = 1'b1;
    step();
    checks++;
    if ({value, tc, err} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_err: got %h/%b/%b want 0000/0/0", value, tc, err);
    end
    clr = 1'b0; limit = 16'h0059; load = 1'b1; load_val = 16'h0070;
    step();
    checks++;
    if ({value, err} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL over_limit_load: got %h/%b want 0000/1", value, err);
    end
    load_val = 16'h0030; clr = 1'b1; load = 1'b0;
    step();
    clr = 1'b0; load = 1'b1;
    step();
    clr = 1'b1; load = 1'b1; load_val = 16'h0040; inc = 1'b1;
    step();
    checks++;
    if ({value, tc, err} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_priority: got %h/%b/%b want 0000/0/0", value, tc, err);
    end
    clr = 1'b0; load_val = 16'h0045;
    step();
    checks++;
    if ({value, tc} !== {16'h0045, 1'b0}) begin
      errors++;
      $display("FAIL load_priority: got %h/%b want 0045/0", value, tc);
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); limit = 16'h9999; load = 1'b1; load_val = 16'h0347;
    step();
    load = 1'b0;
    checks++;
    if (value !== 16'h0347) begin
      errors++;
      $display("FAIL pre_reset_load: got %h want 0347", value);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({value, tc, err} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b want 0000/0/0", value, tc, err);
    end
    #2 rst_n = 1'b1;
    inc = 1'b1;
    step();
    checks++;
    if (value !== 16'h0001) begin
      errors++;
      $display("FAIL first_inc_after_reset: got %h want 0001", value);
    end
    idle();
  endtask

  task automatic test_limit_below();
    idle(); limit = 16'h9999; load = 1'b1; load_val = 16'h0050;
    step();
    load = 1'b0; limit = 16'h0030; inc = 1'b1;
    step();
    exp_v = SAT ? 16'h0030 : 16'h0000;
    checks++;
    if ({value, tc, err} !== {exp_v, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL limit_below_up: got %h/%b/%b want %h/1/1", value, tc, err, exp_v);
    end
    inc = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; limit = 16'h9999; load = 1'b1;
    step();
    load = 1'b0; limit = 16'h0030; inc = 1'b1; dir = 1'b1;
    step();
    checks++;
    if ({value, tc, err} !== {16'h0049, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL limit_below_down: got %h/%b/%b want 0049/0/0", value, tc, err);
    end
    idle(); clr = 1'b1;
    step();
    clr = 1'b0; limit = 16'h00A0; inc = 1'b1;
    step();
    checks++;
    if ({value, tc, err} !== {16'h0001, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bad_limit_digit: got %h/%b/%b want 0001/0/1", value, tc, err);
    end
    idle(); clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    idle(); limit = 16'h0000; inc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({value, tc, err} !== {16'h0000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL back_to_back%0d: got %h/%b/%b want 0000/1/0", k, value, tc, err);
      end
    end
    inc = 1'b0;
    step();
    checks++;
    if ({value, tc} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_idle: got %h/%b want 0000/0", value, tc);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_up_wrap("minutes", 16'h0059, 16'h0058, 16'h0001);
    test_up_wrap("limit99", 16'h0099, 16'h0098, 16'h0001);
    test_down();
    test_bad_load_and_priority();
    test_async_reset();
    test_limit_below();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
Parametrised multi-digit BCD counter for the stopwatch/timer datapath. Counts up or down by one on a qualified step. Supports parallel load, synchronous clear and a programmable terminal value. Wraps between 0 and the terminal value, and reports a one-cycle terminal pulse to cascade into the next timing stage.

Parameters:
NDIG, 4, number of BCD digits; valid range 1..8. Output width is 4*NDIG.
RST_VAL, 0, binary-coded-decimal reset/clear value; must be valid BCD and <= the terminal value.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear to RST_VAL; highest synchronous priority
load  input  1  synchronous parallel load of load_val
load_val  input  4*NDIG  BCD value to load
inc  input  1  count step strobe; one step per cycle while high
dir  input  1  0 = count up, 1 = count down; sampled with inc
limit  input  4*NDIG  BCD terminal value (maximum count), quasi-static
value  output  4*NDIG  current BCD count; digit 0 = bits [3:0]
tc  output  1  registered one-cycle pulse on wrap (up: limit->0, down: 0->limit)
err  output  1  sticky flag: invalid BCD load or limit violation

Behaviour:
- Reset (rst_n low, async):
  - value = RST_VAL, tc = 0, err = 0.
  - Release is synchronous to clk.
- Per-cycle priority:
  - clr > load > inc.
  - Exactly one action per cycle; no action leaves value held and tc = 0.
- clr:
  - value <= RST_VAL, tc <= 0, err <= 0.
- load:
  - If every load_val digit is <= 9 and load_val <= limit: value <= load_val.
  - Otherwise value <= RST_VAL and err <= 1.
  - tc <= 0 in either case.
- inc, dir = 0 (up):
  - If value == limit: value <= 0, tc <= 1.
  - Otherwise digit 0 increments, and each digit i > 0 increments iff all lower digits == 9.
  - A digit going past 9 becomes 0.
- inc, dir = 1 (down):
  - If value == 0: value <= limit, tc <= 1.
  - Otherwise digit 0 decrements, and digit i > 0 decrements iff all lower digits == 0.
  - A digit going below 0 becomes 9.
- Carry/borrow chain:
  - Combinational across all NDIG digits within one cycle.
  - Latency from inc to updated value is 1 clock.
- tc:
  - High only in the cycle after the wrapping step.
  - Back-to-back wraps (e.g. limit = 0 with inc held) give tc high every cycle.
- Limit changed below current value:
  - An up step treats value > limit as the wrap condition: value <= 0, tc <= 1, err <= 1.
  - A down step decrements normally.
- Invalid limit digit (> 9): err <= 1 on the next inc; counting continues using the raw compare.
- err clears only on reset or clr.
- value never holds a digit > 9 in any reachable state.

Optional Feature:
Macro BCD_CNT_SAT_EN.
- Defined:
  - Up at limit holds value = limit; down at 0 holds 0.
  - tc asserts every cycle the held step is requested (saturation indication).
  - No wrap occurs.
  - The out-of-range-limit case loads value <= limit instead of 0.
- Not defined: wrap behaviour as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- NDIG=4, limit=9999, reset then 10000 up steps -> value sequences 0000..9999, then 0000; tc is a single pulse after step 10000; err = 0.
- NDIG=2, limit=59, load 58, dir=0, inc 3 cycles -> value 59, 00, 01; tc high only in the cycle value shows 00.
- NDIG=2, limit=59, value=00, dir=1, one inc -> value 59, tc = 1; next inc -> 58, tc = 0; value 10 with one down step -> 09.
- load_val=0x1A (digit > 9) -> value = RST_VAL, err = 1; clr -> err = 0. clr, load and inc in the same cycle -> RST_VAL wins.
- rst_n asserted mid-count (value 0347) between clock edges -> value = 0000 immediately with no clock; first inc after release -> 0001.
- BCD_CNT_SAT_EN build, limit=99, value 98, 3 up steps -> 99, 99, 99; tc high on the 2nd and 3rd steps. Down from 00 -> holds 00, tc = 1.
